// File: rtl/tpm_pkg.sv
// Shared TPM locality types and constants.
// Used by the SPI decoder and the locality arbiter.
package tpm_pkg;

  localparam int NUM_LOC = 5;
  localparam int LOC_W = 3;
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FLUSH  = 2'd2
  } loc_state_t;

  // TPM_ACCESS register bit positions
  localparam int ACC_REQ_USE = 1;
  localparam int ACC_PEND_REQ = 2;
  localparam int ACC_SEIZE = 3;
  localparam int ACC_BEEN_SEIZED = 4;
  localparam int ACC_ACTIVE_LOC = 5;

  function automatic logic [NUM_LOC-1:0] loc_bit(
    input logic [LOC_W-1:0] l
  );
    logic [NUM_LOC-1:0] one;
    one = {{(NUM_LOC-1){1'b0}}, 1'b1};
    return one << l;
  endfunction

endpackage

// File: rtl/tpm_loc_prio_enc.sv
// Highest-set-bit encoder over the locality vector.
// Higher locality numbers take priority.
module tpm_loc_prio_enc
  import tpm_pkg::*;
(
  input  logic [NUM_LOC-1:0] req,
  output logic [LOC_W-1:0]   idx,
  output logic               valid
);

  always_comb begin
    idx = '0;
    valid = 1'b0;
    for (int i = 0; i < NUM_LOC; i++) begin
      if (req[i]) begin
        idx = LOC_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tpm_locality_arbiter.sv
// TPM locality ownership arbiter with flush handshake
// between ownership handoffs.
module tpm_locality_arbiter
  import tpm_pkg::*;
#(
  parameter int FLUSH_TIMEOUT = 255
) (
  input  logic               CLOCK_50,
  input  logic               RESET_n,
  input  logic [NUM_LOC-1:0] req_use_i,
  input  logic [NUM_LOC-1:0] relinquish_i,
  input  logic [NUM_LOC-1:0] seize_i,
  input  logic [NUM_LOC-1:0] clr_seized_i,
  input  logic               flush_done_i,
  output logic [LOC_W-1:0]   active_loc_o,
  output logic               active_valid_o,
  output logic [NUM_LOC-1:0] pending_o,
  output logic [NUM_LOC-1:0] been_seized_o,
  output logic               flush_req_o,
  output logic               flush_timeout_o
);

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(FLUSH_TIMEOUT - 1);

  loc_state_t         state, state_n;
  logic [LOC_W-1:0]   cur_loc, cur_n;
  logic [LOC_W-1:0]   tgt_loc, tgt_n;
  logic               tgt_valid, tgt_v_n;
  logic               from_relq, relq_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [NUM_LOC-1:0] req_pend, pend_n;
  logic [NUM_LOC-1:0] seized, seized_set;

  logic [NUM_LOC-1:0] act_mask;
  logic [NUM_LOC-1:0] above;
  logic [NUM_LOC-1:0] seize_ok;
  logic [NUM_LOC-1:0] pend_merged;
  logic [LOC_W-1:0]   s_idx, g_idx, x_idx;
  logic               s_valid, g_valid, x_valid;
  logic               is_active, is_flush;
  logic               at_last, leave;

  assign is_active = (state == ACTIVE);
  assign is_flush = (state == FLUSH);

  always_comb begin
    above = '0;
    for (int i = 0; i < NUM_LOC; i++) begin
      above[i] = (LOC_W'(i) > cur_loc);
    end
  end

  assign act_mask = is_active ? loc_bit(cur_loc) : '0;
  assign seize_ok = is_active ? (seize_i & above) : '0;

  // relinquish beats a same-cycle request for the same locality
  assign pend_merged =
    (req_pend | (req_use_i & ~act_mask)) & ~relinquish_i;

  tpm_loc_prio_enc u_seize_enc (
    .req   (seize_ok),
    .idx   (s_idx),
    .valid (s_valid)
  );

  tpm_loc_prio_enc u_grant_enc (
    .req   (pend_merged),
    .idx   (g_idx),
    .valid (g_valid)
  );

  assign at_last = (cnt == CNT_LAST);
  assign leave = is_flush && (flush_done_i || at_last);
  assign x_valid = from_relq ? g_valid : tgt_valid;
  assign x_idx = from_relq ? g_idx : tgt_loc;

  always_comb begin
    state_n = state;
    cur_n = cur_loc;
    tgt_n = tgt_loc;
    tgt_v_n = tgt_valid;
    relq_n = from_relq;
    cnt_n = cnt;
    pend_n = pend_merged;
    seized_set = '0;
    unique case (state)
      IDLE: begin
        if (g_valid) begin
          state_n = ACTIVE;
          cur_n = g_idx;
          pend_n = pend_merged & ~loc_bit(g_idx);
        end
      end
      ACTIVE: begin
        if (s_valid) begin
          state_n = FLUSH;
          tgt_v_n = 1'b1;
          tgt_n = s_idx;
          relq_n = 1'b0;
          cnt_n = '0;
          seized_set = loc_bit(cur_loc);
          pend_n = pend_merged & ~loc_bit(s_idx);
        end else if (|(relinquish_i & act_mask)) begin
          state_n = FLUSH;
          tgt_v_n = g_valid;
          tgt_n = g_idx;
          relq_n = 1'b1;
          cnt_n = '0;
        end
      end
      FLUSH: begin
        if (leave) begin
          cnt_n = '0;
          if (x_valid) begin
            state_n = ACTIVE;
            cur_n = x_idx;
            pend_n = pend_merged & ~loc_bit(x_idx);
          end else begin
            state_n = IDLE;
          end
        end else if (cnt != '1) begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_n) begin
    if (!RESET_n) begin
      state <= IDLE;
      cur_loc <= '0;
      tgt_loc <= '0;
      tgt_valid <= 1'b0;
      from_relq <= 1'b0;
      cnt <= '0;
      req_pend <= '0;
      seized <= '0;
    end else begin
      state <= state_n;
      cur_loc <= cur_n;
      tgt_loc <= tgt_n;
      tgt_valid <= tgt_v_n;
      from_relq <= relq_n;
      cnt <= cnt_n;
      req_pend <= pend_n;
      seized <= (seized & ~clr_seized_i) | seized_set;
    end
  end

  always_comb begin
    pending_o = '0;
    for (int l = 0; l < NUM_LOC; l++) begin
      pending_o[l] = |(req_pend & ~loc_bit(LOC_W'(l)));
    end
  end

  assign active_valid_o = is_active;
  assign active_loc_o = is_active ? cur_loc : '0;
  assign been_seized_o = seized;
  assign flush_req_o = is_flush;
  assign flush_timeout_o = is_flush && at_last && !flush_done_i;

endmodule

// File: tb/tb_tpm_locality_arbiter.sv
// Directed checks of locality grant, handoff, seize,
// flush timeout and asynchronous reset.
module tb_tpm_locality_arbiter;
  import tpm_pkg::*;

  logic               clk;
  logic               rst_n;
  logic [NUM_LOC-1:0] req_use;
  logic [NUM_LOC-1:0] relinq;
  logic [NUM_LOC-1:0] seize;
  logic [NUM_LOC-1:0] clr_seized;
  logic               flush_done;
  logic [LOC_W-1:0]   active_loc;
  logic               active_valid;
  logic [NUM_LOC-1:0] pending;
  logic [NUM_LOC-1:0] been_seized;
  logic               flush_req;
  logic               flush_timeout;

  int n_chk = 0;
  int n_fail = 0;

  tpm_locality_arbiter dut (
    .CLOCK_50        (clk),
    .RESET_n         (rst_n),
    .req_use_i       (req_use),
    .relinquish_i    (relinq),
    .seize_i         (seize),
    .clr_seized_i    (clr_seized),
    .flush_done_i    (flush_done),
    .active_loc_o    (active_loc),
    .active_valid_o  (active_valid),
    .pending_o       (pending),
    .been_seized_o   (been_seized),
    .flush_req_o     (flush_req),
    .flush_timeout_o (flush_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_use = '0;
    relinq = '0;
    seize = '0;
    clr_seized = '0;
    flush_done = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_loc"}, 32'(active_loc), 0);
    check({tag, "_valid"}, 32'(active_valid), 0);
    check({tag, "_pend"}, 32'(pending), 0);
    check({tag, "_seized"}, 32'(been_seized), 0);
    check({tag, "_flush"}, 32'(flush_req), 0);
    check({tag, "_tmo"}, 32'(flush_timeout), 0);
  endtask

  task automatic finish_flush();
    flush_done = 1'b1;
    step();
    flush_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int pulse_at;
    int pulses;
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    check_all_zero("reset");
    rst_n = 1'b1;
    step();

    // request grant: exactly one cycle after the pulse
    req_use = 5'b00100;
    step();
    req_use = '0;
    check("grant_valid", 32'(active_valid), 1);
    check("grant_loc", 32'(active_loc), 2);
    check("grant_pend", 32'(pending), 0);

    // flush_done outside FLUSH is ignored
    flush_done = 1'b1;
    step();
    flush_done = 1'b0;
    check("fd_ign_loc", 32'(active_loc), 2);
    check("fd_ign_flush", 32'(flush_req), 0);

    // relinquish handoff 2 -> 4
    req_use = 5'b10000;
    step();
    req_use = '0;
    check("pend_4", 32'(pending), 32'h0F);
    relinq = 5'b00100;
    step();
    relinq = '0;
    check("rel_flush", 32'(flush_req), 1);
    check("rel_valid", 32'(active_valid), 0);
    check("rel_loc", 32'(active_loc), 0);
    step();
    step();
    check("rel_hold", 32'(flush_req), 1);
    finish_flush();
    check("hand_loc", 32'(active_loc), 4);
    check("hand_valid", 32'(active_valid), 1);
    check("hand_flush", 32'(flush_req), 0);
    check("hand_pend", 32'(pending), 0);

    // move to locality 1
    req_use = 5'b00010;
    relinq = 5'b10000;
    step();
    idle_inputs();
    check("to1_flush", 32'(flush_req), 1);
    finish_flush();
    check("to1_loc", 32'(active_loc), 1);

    // seize from a lower locality is ignored
    seize = 5'b00001;
    step();
    seize = '0;
    check("sz0_loc", 32'(active_loc), 1);
    check("sz0_flush", 32'(flush_req), 0);
    check("sz0_seized", 32'(been_seized), 0);

    // two seizes: highest wins
    seize = 5'b01100;
    step();
    seize = '0;
    check("sz_seized", 32'(been_seized), 32'h02);
    check("sz_flush", 32'(flush_req), 1);
    finish_flush();
    check("sz_loc", 32'(active_loc), 3);
    check("sz_valid", 32'(active_valid), 1);

    // move to locality 0
    req_use = 5'b00001;
    relinq = 5'b01000;
    step();
    idle_inputs();
    finish_flush();
    check("to0_loc", 32'(active_loc), 0);
    check("to0_valid", 32'(active_valid), 1);

    // same-cycle request and relinquish of 3
    req_use = 5'b01000;
    relinq = 5'b01000;
    step();
    idle_inputs();
    check("coll_pend", 32'(pending), 0);
    step();
    check("coll_stay", 32'(active_loc), 0);

    // move to locality 1, then seize with a clear
    req_use = 5'b00010;
    relinq = 5'b00001;
    step();
    idle_inputs();
    finish_flush();
    check("to1b_loc", 32'(active_loc), 1);
    seize = 5'b01000;
    clr_seized = 5'b00010;
    step();
    idle_inputs();
    check("setclr_seized", 32'(been_seized), 32'h02);
    check("setclr_flush", 32'(flush_req), 1);
    clr_seized = 5'b00010;
    step();
    clr_seized = '0;
    check("clr_seized", 32'(been_seized), 0);
    finish_flush();
    check("to3_loc", 32'(active_loc), 3);

    // timeout with nothing pending
    relinq = 5'b01000;
    step();
    relinq = '0;
    n = 0;
    pulse_at = 0;
    pulses = 0;
    while (flush_req && n < 400) begin
      n++;
      if (flush_timeout) begin
        pulses++;
        pulse_at = n;
      end
      step();
    end
    check("tmo_cycles", 32'(n), 255);
    check("tmo_pulse_at", 32'(pulse_at), 255);
    check("tmo_pulses", 32'(pulses), 1);
    check("tmo_idle_valid", 32'(active_valid), 0);
    check("tmo_idle_flush", 32'(flush_req), 0);
    check("tmo_idle_tmo", 32'(flush_timeout), 0);

    // reset mid-FLUSH
    req_use = 5'b00100;
    step();
    req_use = '0;
    check("pre_rst_loc", 32'(active_loc), 2);
    seize = 5'b10000;
    step();
    seize = '0;
    check("pre_rst_flush", 32'(flush_req), 1);
    check("pre_rst_seized", 32'(been_seized), 32'h04);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_rst");
    step();
    rst_n = 1'b1;
    step();
    check_all_zero("post_rst");
    req_use = 5'b00001;
    step();
    req_use = '0;
    check("post_rst_valid", 32'(active_valid), 1);
    check("post_rst_loc", 32'(active_loc), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
